// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared constants for the CPU bus arbiter.
// Holds the default sizing, the bus source index map, the arbiter state
// type and a modulo-increment helper.
package bus_arb_pkg;
  localparam int NUM_REQ_DEF = 24;
  localparam int MAX_HOLD_DEF = 4;
  localparam int SEL_W = $clog2(NUM_REQ_DEF);
  localparam int SRC_R0 = 0;
  localparam int SRC_R1 = 1;
  localparam int SRC_R2 = 2;
  localparam int SRC_R3 = 3;
  localparam int SRC_R4 = 4;
  localparam int SRC_R5 = 5;
  localparam int SRC_R6 = 6;
  localparam int SRC_R7 = 7;
  localparam int SRC_R8 = 8;
  localparam int SRC_R9 = 9;
  localparam int SRC_R10 = 10;
  localparam int SRC_R11 = 11;
  localparam int SRC_R12 = 12;
  localparam int SRC_R13 = 13;
  localparam int SRC_R14 = 14;
  localparam int SRC_R15 = 15;
  localparam int SRC_HI = 16;
  localparam int SRC_LO = 17;
  localparam int SRC_ZHI = 18;
  localparam int SRC_ZLO = 19;
  localparam int SRC_PC = 20;
  localparam int SRC_MDR = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C = 23;
  typedef enum logic {ST_IDLE, ST_OWN} arb_state_e;
  function automatic int wrap_inc(input int i, input int n);
    return (i >= n - 1) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports: req (request mask), start (first index to try) ->
//        onehot (chosen bit), idx (chosen index, 0 if none), found.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int N = NUM_REQ_DEF,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         found
);
  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(start) + i) % N]) begin
        idx = W'((int'(start) + i) % N);
        found = 1'b1;
      end
    end
    onehot = found ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the 32-bit CPU bus out-enables with hold limit.
// Ports: clk, clr (sync, active-low), req[NUM_REQ] in;
//        grant (one-hot), sel (owner index), busy, preempt (1-cycle) out, all registered.
// Option: BUS_ARB_PRIO0_EN gives requester 0 strict priority at every arbitration point.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] sel,
  output logic                       busy,
  output logic                       preempt
);
  localparam int W = $clog2(NUM_REQ);
  localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  arb_state_e state;
  logic [W-1:0] last, start, pk_idx;
  logic [HW-1:0] hold_cnt;
  logic [NUM_REQ-1:0] mask, pick_mask, pk_oh;
  logic pk_found, own_req, at_lim, keep, do_pre;
  // The current owner never competes in its own handover or preemption.
  assign mask = req & ~grant;
`ifdef BUS_ARB_PRIO0_EN
  assign pick_mask = mask[0] ? NUM_REQ'(1) : mask;
`else
  assign pick_mask = mask;
`endif
  // last equals the owner while busy, so one start index serves every case.
  assign start = W'(wrap_inc(int'(last), NUM_REQ));
  assign own_req = |(req & grant);
  assign at_lim = int'(hold_cnt) >= MAX_HOLD - 1;
  assign keep = state == ST_OWN && own_req && !(at_lim && |mask);
  assign do_pre = state == ST_OWN && own_req && !keep;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req(pick_mask),
    .start(start),
    .onehot(pk_oh),
    .idx(pk_idx),
    .found(pk_found)
  );
  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= ST_IDLE;
      grant <= '0;
      sel <= '0;
      busy <= 1'b0;
      preempt <= 1'b0;
      hold_cnt <= '0;
      last <= W'(NUM_REQ - 1);
    end else if (keep) begin
      hold_cnt <= at_lim ? hold_cnt : hold_cnt + 1'b1;
      preempt <= 1'b0;
    end else begin
      state <= pk_found ? ST_OWN : ST_IDLE;
      grant <= pk_oh;
      sel <= pk_idx;
      busy <= pk_found;
      preempt <= do_pre;
      hold_cnt <= '0;
      if (pk_found) last <= pk_idx;
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table-driven check of bus_arbiter plus per-cycle grant invariants.
module tb_bus_arbiter;
  typedef struct {
    logic        clr;
    logic [23:0] req;
    int          idx;
    logic        pre;
  } vec_t;
`ifdef BUS_ARB_PRIO0_EN
  localparam int PS = 0;
`else
  localparam int PS = 12;
`endif
  logic clk = 1'b0, clr = 1'b0, run = 1'b0;
  logic [23:0] req = '0, grant;
  logic [4:0] sel;
  logic busy, preempt;
  int checks = 0, errors = 0;
  vec_t vq[$];
  bus_arbiter dut (
    .clk(clk),
    .clr(clr),
    .req(req),
    .grant(grant),
    .sel(sel),
    .busy(busy),
    .preempt(preempt)
  );
  always #5 clk = ~clk;
  function automatic logic [23:0] b(input int n);
    logic [23:0] one = 24'd1;
    return one << n;
  endfunction
  function automatic void add(input logic c, input logic [23:0] r, input int i, input logic p);
    vec_t v;
    v.clr = c;
    v.req = r;
    v.idx = i;
    v.pre = p;
    vq.push_back(v);
  endfunction
  always @(negedge clk) begin
    if (run) begin
      int exp_sel;
      exp_sel = 0;
      for (int k = 0; k < 24; k++) if (grant[k]) exp_sel = k;
      checks += 3;
      if (!$onehot0(grant)) begin
        errors++;
        $display("FAIL onehot0 grant got %h", grant);
      end
      if (sel !== 5'(exp_sel)) begin
        errors++;
        $display("FAIL sel_vs_grant sel got %0d want %0d (grant %h)", sel, exp_sel, grant);
      end
      if (busy !== |grant) begin
        errors++;
        $display("FAIL busy_vs_grant busy got %b want %b", busy, |grant);
      end
    end
  end
  initial begin
    for (int i = 0; i < 3; i++) add(0, '1, -1, 0);
    for (int i = 0; i < 6; i++) add(1, b(20), 20, 0);
    add(1, 0, -1, 0);
    add(0, 0, -1, 0);
    add(1, b(3) | b(7) | b(21), 3, 0);
    add(1, b(7) | b(21), 7, 0);
    add(1, b(3) | b(21), 21, 0);
    add(1, b(3) | b(7), 3, 0);
    add(1, b(7) | b(21), 7, 0);
    add(1, 0, -1, 0);
    for (int i = 0; i < 4; i++) add(1, b(5) | b(6), 5, 0);
    add(1, b(5) | b(6), 6, 1);
    for (int i = 0; i < 3; i++) add(1, b(5) | b(6), 6, 0);
    add(1, b(5) | b(6), 5, 1);
    add(1, b(5) | b(6), 5, 0);
    add(0, 0, -1, 0);
    add(1, b(23), 23, 0);
    add(1, b(0) | b(22), 0, 0);
    add(1, b(0) | b(22), 0, 0);
    add(0, b(0) | b(22), -1, 0);
    add(1, b(9), 9, 0);
    for (int i = 0; i < 3; i++) add(1, b(0) | b(9) | b(12), 9, 0);
    add(1, b(0) | b(9) | b(12), PS, 1);
    add(1, 0, -1, 0);
    foreach (vq[n]) begin
      logic [23:0] eg;
      logic [4:0] es;
      clr = vq[n].clr;
      req = vq[n].req;
      @(posedge clk);
      #1;
      eg = (vq[n].idx < 0) ? 24'd0 : b(vq[n].idx);
      es = (vq[n].idx < 0) ? 5'd0 : 5'(vq[n].idx);
      checks += 4;
      if (grant !== eg) begin
        errors++;
        $display("FAIL row%0d grant got %h want %h", n, grant, eg);
      end
      if (sel !== es) begin
        errors++;
        $display("FAIL row%0d sel got %0d want %0d", n, sel, es);
      end
      if (busy !== (vq[n].idx >= 0)) begin
        errors++;
        $display("FAIL row%0d busy got %b want %b", n, busy, vq[n].idx >= 0);
      end
      if (preempt !== vq[n].pre) begin
        errors++;
        $display("FAIL row%0d preempt got %b want %b", n, preempt, vq[n].pre);
      end
      run = 1'b1;
    end
    @(negedge clk);
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
